decode_stage_pipelined: RTL and testbench
=========================================

// Module: decode_stage_pipelined
// PURPOSE
// Parametrised, registered instruction-decode stage for the pipelined LEGv8 CPU.
// Holds the IF/ID register and owns the register file (WB write bypass, X31 = zero).
// Produces a registered ID/EX bundle and detects load-use hazards (stall + bubble).
// Sits between the fetch stage and the ID/EX consumers (execute, forwarding unit).
// PARAMETERS
// DATA_W    64  register / immediate / PC datapath width
// ZERO_REG  31  register index that reads 0 and ignores writes
// BYPASS    1   1: a WB write to the read address returns wb_data in the same cycle; 0: old value
// HAZARD_EN 1   1: load-use detection active; 0: id_stall tied 0
// PORTS
// clk          in   1       clock, rising edge
// reset        in   1       synchronous, active-high
// if_valid     in   1       fetch presents a valid instruction
// if_instr     in   32      fetched instruction
// if_pc        in   DATA_W  PC of if_instr
// id_reg2loc   in   1       control for held instr: 0 -> B reads Rd[4:0], 1 -> B reads Rm[20:16]
// id_uncond_br in   1       control for held instr: 0 -> condAddr19 [23:5], 1 -> brAddr26 [25:0]
// ex_memread   in   1       instruction currently in EX is a load
// ex_rd        in   5       destination register of the instruction in EX
// flush        in   1       taken branch: kill IF/ID and ID/EX contents
// wb_regwrite  in   1       WB write enable
// wb_rd        in   5       WB destination
// wb_data      in   DATA_W  WB write data
// id_stall     out  1       combinational; 1 = hold PC and IF/ID this cycle
// idex_valid   out  1       ID/EX bundle valid
// idex_rn, idex_rm, idex_rd  out 5 each   register fields of the decoded instruction
// idex_a, idex_b   out  DATA_W  register read data (A: Rn; B: reg2loc-selected address)
// idex_imm12   out  DATA_W  zero-extended instr[21:10]
// idex_daddr9  out  DATA_W  sign-extended instr[20:12]
// idex_braddr  out  DATA_W  sign-extended branch offset, unshifted
// idex_pc      out  DATA_W  PC of the decoded instruction
// BEHAVIOUR
// - Reset (synchronous): IF/ID valid = 0, instr = 0, pc = 0; all idex_* = 0;
//   all register-file entries = 0. id_stall = 0 while IF/ID is invalid.
// - IF/ID load at posedge: on flush -> valid = 0; else if id_stall -> hold;
//   else valid <= if_valid, instr/pc <= if_instr/if_pc.
// - Decode is combinational from IF/ID. ID/EX loads every cycle. Latency: if_instr to idex_* = 2 edges.
// - ID/EX load: on flush or id_stall -> idex_valid <= 0, other idex_* hold their values.
//   Otherwise idex_valid <= IF/ID valid and all fields load.
// - Hazard: id_stall = HAZARD_EN & IF/ID valid & ex_memread & ex_rd != ZERO_REG & (ex_rd == Rn | ex_rd == B address).
//   A stall lasts exactly one cycle, because the bubble clears ex_memread upstream.
// - Priority: reset > flush > stall. flush together with stall -> flush behaviour; id_stall is not asserted to fetch.
// - Register file: write at posedge when wb_regwrite and wb_rd != ZERO_REG.
//   Reads of ZERO_REG return 0, including when a bypass would otherwise apply.
//   BYPASS=1: same-cycle WB to a read address -> read returns wb_data.
// - Width rules: imm12 zero-extended. daddr9, cond19 and br26 sign-extended from their MSB to DATA_W.
//   No left shift (execute applies the <<2).
// - Reset mid-stall or mid-flush: reset wins and all state clears at that edge.
// TESTING
// 1 ADDI X0,X31,#0 (0x910003E0) valid, X31 nonzero write attempted -> 2 edges later idex_a=0, idex_imm12=0, idex_valid=1.
// 2 wb_regwrite=1 wb_rd=1 wb_data=0x55 in the same cycle as a decode reading X1 (BYPASS=1) -> idex_a=0x55. BYPASS=0 -> old value 0.
// 3 ex_memread=1 ex_rd=2 and held instr reads Rn=X2 -> id_stall=1 for 1 cycle; next idex_valid=0; instr re-issued with idex_valid=1 after.
// 4 B #2 (0x14000002), uncond_br=1 -> idex_braddr=2. CBZ with condAddr19=0x7FFFF -> idex_braddr=all ones (-1).
// 5 flush=1 asserted with a hazard pending -> id_stall=0, next idex_valid=0, IF/ID valid=0.
// 6 reset asserted mid-stall -> next edge: all idex_*=0, register file reads 0 for X0..X30.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// LEGv8 decode stage: IF/ID register, register file (X31 = zero, optional WB bypass), and registered ID/EX bundle; if_instr to idex_* takes 2 edges.
// A load-use hazard raises a combinational id_stall for one cycle, which holds IF/ID and sends a bubble into ID/EX; flush overrides stall.
module decode_stage_pipelined #(
  parameter int DATA_W    = 64,
  parameter int ZERO_REG  = 31,
  parameter int BYPASS    = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              id_reg2loc,
  input  logic              id_uncond_br,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              idex_valid,
  output logic [4:0]        idex_rn,
  output logic [4:0]        idex_rm,
  output logic [4:0]        idex_rd,
  output logic [DATA_W-1:0] idex_a,
  output logic [DATA_W-1:0] idex_b,
  output logic [DATA_W-1:0] idex_imm12,
  output logic [DATA_W-1:0] idex_daddr9,
  output logic [DATA_W-1:0] idex_braddr,
  output logic [DATA_W-1:0] idex_pc
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  typedef struct packed {
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [4:0]        rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm12;
    logic [DATA_W-1:0] daddr9;
    logic [DATA_W-1:0] braddr;
    logic [DATA_W-1:0] pc;
  } idex_t;

  logic              ifid_valid;
  logic [31:0]       ifid_instr;
  logic [DATA_W-1:0] ifid_pc;
  logic [DATA_W-1:0] rf [32];

  logic [4:0]        b_addr;
  logic              byp_a;
  logic              byp_b;
  logic              hazard;
  idex_t             dec;
  idex_t             idex_q;
  logic              idex_valid_q;
  logic              unused_opcode;

  assign unused_opcode = ^ifid_instr[31:26];

  // Read ports: zero register wins over bypass, bypass wins over stored value.
  always_comb begin
    dec        = '0;
    b_addr     = id_reg2loc ? ifid_instr[20:16] : ifid_instr[4:0];
    byp_a      = (BYPASS != 0) && wb_regwrite && (wb_rd == ifid_instr[9:5]);
    byp_b      = (BYPASS != 0) && wb_regwrite && (wb_rd == b_addr);
    dec.rn     = ifid_instr[9:5];
    dec.rm     = ifid_instr[20:16];
    dec.rd     = ifid_instr[4:0];
    dec.a      = (dec.rn == ZR) ? '0 : (byp_a ? wb_data : rf[dec.rn]);
    dec.b      = (b_addr == ZR) ? '0 : (byp_b ? wb_data : rf[b_addr]);
    dec.imm12  = {{(DATA_W-12){1'b0}}, ifid_instr[21:10]};
    dec.daddr9 = {{(DATA_W-9){ifid_instr[20]}}, ifid_instr[20:12]};
    dec.braddr = id_uncond_br ? {{(DATA_W-26){ifid_instr[25]}}, ifid_instr[25:0]}
                              : {{(DATA_W-19){ifid_instr[23]}}, ifid_instr[23:5]};
    dec.pc     = ifid_pc;
  end

  assign hazard = ifid_valid && ex_memread && (ex_rd != ZR) &&
                  ((ex_rd == ifid_instr[9:5]) || (ex_rd == b_addr));

  // Flush and reset both take precedence, so fetch never sees a stall then.
  assign id_stall = (HAZARD_EN != 0) && hazard && !flush && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (!id_stall) begin
      ifid_valid <= if_valid;
      ifid_instr <= if_instr;
      ifid_pc    <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_valid_q <= 1'b0;
      idex_q       <= '0;
    end else if (flush || id_stall) begin
      idex_valid_q <= 1'b0;
    end else begin
      idex_valid_q <= ifid_valid;
      idex_q       <= dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_regwrite && (wb_rd != ZR)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  assign idex_valid  = idex_valid_q;
  assign idex_rn     = idex_q.rn;
  assign idex_rm     = idex_q.rm;
  assign idex_rd     = idex_q.rd;
  assign idex_a      = idex_q.a;
  assign idex_b      = idex_q.b;
  assign idex_imm12  = idex_q.imm12;
  assign idex_daddr9 = idex_q.daddr9;
  assign idex_braddr = idex_q.braddr;
  assign idex_pc     = idex_q.pc;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: directed cases plus randomized traffic,
// checked against an instruction-level model of the stage (BYPASS=1 and BYPASS=0 instances).
module tb_decode_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset, if_valid, id_reg2loc, id_uncond_br, ex_memread, flush, wb_regwrite;
  logic [31:0] if_instr;
  logic [63:0] if_pc, wb_data;
  logic [4:0]  ex_rd, wb_rd;

  logic        id_stall, idex_valid;
  logic [4:0]  idex_rn, idex_rm, idex_rd;
  logic [63:0] idex_a, idex_b, idex_imm12, idex_daddr9, idex_braddr, idex_pc;

  logic        nb_stall, nb_valid;
  logic [4:0]  nb_rn, nb_rm, nb_rd;
  logic [63:0] nb_a, nb_b, nb_imm12, nb_daddr9, nb_braddr, nb_pc;

  always #5 clk = ~clk;

  decode_stage_pipelined dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_reg2loc(id_reg2loc), .id_uncond_br(id_uncond_br), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .id_stall(id_stall), .idex_valid(idex_valid), .idex_rn(idex_rn),
    .idex_rm(idex_rm), .idex_rd(idex_rd), .idex_a(idex_a), .idex_b(idex_b),
    .idex_imm12(idex_imm12), .idex_daddr9(idex_daddr9), .idex_braddr(idex_braddr),
    .idex_pc(idex_pc)
  );

  decode_stage_pipelined #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_reg2loc(id_reg2loc), .id_uncond_br(id_uncond_br), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .id_stall(nb_stall), .idex_valid(nb_valid), .idex_rn(nb_rn),
    .idex_rm(nb_rm), .idex_rd(nb_rd), .idex_a(nb_a), .idex_b(nb_b),
    .idex_imm12(nb_imm12), .idex_daddr9(nb_daddr9), .idex_braddr(nb_braddr),
    .idex_pc(nb_pc)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rn, rm, rd;
    logic [63:0] a, b, imm12, daddr9, braddr, pc, a_nb, b_nb;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_exp;
  logic [63:0] m_regs [32];
  logic        m_v;
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  logic [63:0] pc_ctr;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] mread(input logic [4:0] addr, input bit byp, input logic we,
                                        input logic [4:0] wrd, input logic [63:0] wd);
    if (addr == 5'd31) return 64'd0;
    if (byp && we && wrd == addr) return wd;
    return m_regs[addr];
  endfunction

  // Sign extension done arithmetically: subtract 2^n when the field's MSB is set.
  function automatic logic [63:0] sext(input longint raw, input int bits);
    longint v;
    v = raw;
    if (raw >= (64'sd1 <<< (bits - 1))) v = raw - (64'sd1 <<< bits);
    return 64'(v);
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic r2l = 0,
                       input logic ub = 0, input logic emr = 0, input logic [4:0] erd = 0,
                       input logic fl = 0, input logic we = 0, input logic [4:0] wrd = 0,
                       input logic [63:0] wd = 0, input logic rst = 0);
    logic [4:0] rn, rm, rd, baddr;
    bit         stall_exp;
    @(negedge clk);
    reset = rst; if_valid = v; if_instr = ins; if_pc = pc_ctr; id_reg2loc = r2l;
    id_uncond_br = ub; ex_memread = emr; ex_rd = erd; flush = fl;
    wb_regwrite = we; wb_rd = wrd; wb_data = wd;
    pc_ctr = pc_ctr + 64'd4;
    #1;
    rn = m_instr[9:5]; rm = m_instr[20:16]; rd = m_instr[4:0];
    baddr = r2l ? rm : rd;
    stall_exp = !rst && !fl && m_v && emr && erd != 5'd31 && (erd == rn || erd == baddr);
    if (!rst) begin
      chk("id_stall", {63'd0, id_stall}, {63'd0, stall_exp});
      chk("id_stall_nb", {63'd0, nb_stall}, {63'd0, stall_exp});
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_v = 0; m_instr = 0; m_pc = 0; m_exp = '0;
    end else begin
      if (fl || stall_exp) begin
        m_exp.valid = 1'b0;
      end else begin
        m_exp.valid  = m_v;
        m_exp.rn     = rn;
        m_exp.rm     = rm;
        m_exp.rd     = rd;
        m_exp.a      = mread(rn, 1, we, wrd, wd);
        m_exp.b      = mread(baddr, 1, we, wrd, wd);
        m_exp.a_nb   = mread(rn, 0, we, wrd, wd);
        m_exp.b_nb   = mread(baddr, 0, we, wrd, wd);
        m_exp.imm12  = 64'(m_instr[21:10]);
        m_exp.daddr9 = sext(longint'(m_instr[20:12]), 9);
        m_exp.braddr = ub ? sext(longint'(m_instr[25:0]), 26) : sext(longint'(m_instr[23:5]), 19);
        m_exp.pc     = m_pc;
      end
      if (fl) m_v = 0;
      else if (!stall_exp) begin m_v = v; m_instr = ins; m_pc = if_pc; end
      if (we && wrd != 5'd31) m_regs[wrd] = wd;
    end
    sb_q.push_back(m_exp);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("idex_valid", {63'd0, idex_valid}, {63'd0, e.valid});
      chk("idex_rn", {59'd0, idex_rn}, {59'd0, e.rn});
      chk("idex_rm", {59'd0, idex_rm}, {59'd0, e.rm});
      chk("idex_rd", {59'd0, idex_rd}, {59'd0, e.rd});
      chk("idex_a", idex_a, e.a);
      chk("idex_b", idex_b, e.b);
      chk("idex_imm12", idex_imm12, e.imm12);
      chk("idex_daddr9", idex_daddr9, e.daddr9);
      chk("idex_braddr", idex_braddr, e.braddr);
      chk("idex_pc", idex_pc, e.pc);
      chk("nb_valid", {63'd0, nb_valid}, {63'd0, e.valid});
      chk("nb_a", nb_a, e.a_nb);
      chk("nb_b", nb_b, e.b_nb);
      chk("nb_fields", {nb_rn, nb_rm, nb_rd, nb_imm12[11:0]}, {e.rn, e.rm, e.rd, e.imm12[11:0]});
      chk("nb_offsets", nb_daddr9 ^ nb_braddr ^ nb_pc, e.daddr9 ^ e.braddr ^ e.pc);
    end
  end

  initial begin
    logic [31:0] ins;
    logic [4:0]  f;
    reset = 1; if_valid = 0; if_instr = 0; if_pc = 0; id_reg2loc = 0; id_uncond_br = 0;
    ex_memread = 0; ex_rd = 0; flush = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    pc_ctr = 64'h1000; m_v = 0; m_instr = 0; m_pc = 0; m_exp = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;

    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ADDI X0,X31,#0 while a write to X31 is attempted
    drive(1, 32'h910003E0, 0, 0, 0, 0, 0, 1, 5'd31, 64'hDEAD);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd31, 64'hBEEF);
    drive(0, 0);

    // ADD X3,X1,X2 decoded in the same cycle WB writes X1
    drive(1, 32'h8B020023);
    drive(0, 0, 1, 0, 0, 0, 0, 1, 5'd1, 64'h55);
    drive(0, 0);

    // LDUR X1,[X2] held while EX load targets X2: one stall then reissue
    drive(1, 32'hF8400041);
    drive(1, 32'h8B020023, 0, 0, 1, 5'd2);
    drive(1, 32'h8B020023, 0, 0, 0, 5'd2);
    drive(0, 0);
    drive(0, 0);

    // B #2 and CBZ with condAddr19 = all ones
    drive(1, 32'h14000002);
    drive(1, 32'hB4FFFFE0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0);

    // flush with a hazard pending
    drive(1, 32'hF8400041);
    drive(1, 32'h8B020023, 0, 0, 1, 5'd2, 1);
    drive(0, 0);
    drive(0, 0);

    // randomized traffic with a small register pool so hazards and bypasses occur
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      f = 5'($urandom_range(0, 4)); ins[9:5]   = (f == 5'd4) ? 5'd31 : f;
      f = 5'($urandom_range(0, 4)); ins[20:16] = (f == 5'd4) ? 5'd31 : f;
      f = 5'($urandom_range(0, 4)); ins[4:0]   = (f == 5'd4) ? 5'd31 : f;
      f = 5'($urandom_range(0, 4));
      drive($urandom_range(0, 3) != 0, ins, 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
            1'($urandom), (f == 5'd4) ? 5'd31 : f, {$urandom, $urandom},
            $urandom_range(0, 99) == 0);
    end

    // fill X0..X30, then reset in the middle of a stall
    for (int i = 0; i < 31; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 5'(i), {$urandom, 32'h1} | 64'h1);
    drive(1, 32'hF8400041);
    drive(1, 32'h8B020023, 0, 0, 1, 5'd2);
    drive(1, 32'h8B020023, 0, 0, 1, 5'd2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 31; i++) begin
      ins = 32'h8B000000 | (32'(i) << 16) | (32'(i) << 5) | 32'(i);
      drive(1, ins, 1);
    end
    drive(0, 0, 1);
    drive(0, 0);

    @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
